mac_dot_seq: RTL and testbench

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

---
 rtl/mac_dot_seq.sv | 99 +++++++++
 tb/tb_mac_dot_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences a TAPS-long signed dot product through an external 16x16 MAC.
// Define MAC_DOT_SEQ_SAT_EN to saturate each result to signed 16-bit before it is sign-extended.
module mac_dot_seq #(
   parameter int TAPS     = 4,
   parameter int PIPE_LAT = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        S_VALID,
   output logic        S_READY,
   input  logic [15:0] S_A,
   input  logic [15:0] S_B,
   output logic [15:0] MAC_A,
   output logic [15:0] MAC_B,
   output logic        MAC_OHHLD,
   output logic        MAC_OLHLD,
   output logic        MAC_OHLDA,
   output logic        MAC_OLLDA,
   output logic        MAC_OHADS,
   output logic        MAC_OLADS,
   input  logic [31:0] MAC_O,
   output logic        R_VALID,
   input  logic        R_READY,
   output logic [31:0] R_DATA
);
   localparam int CW = $clog2(TAPS + 1);
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PIPE_LAT-1:0] iss_q, iss_d, fst_q, fst_d;
   logic [15:0]         a_q, a_d, b_q, b_d;
   logic [31:0]         rdata_q, rdata_d, res;
   logic                rvalid_q, rvalid_d, last_q, last_d, alive_q;
   logic                accept, drained, capture, done;
   assign accept  = S_VALID && S_READY;
   assign drained = state_q == DRAIN && iss_q == '0;
   assign capture = drained && last_q;
   assign done    = state_q == OUT && R_READY;
`ifdef MAC_DOT_SEQ_SAT_EN
   assign res = ($signed(MAC_O) > 32'sd32767)  ? 32'h0000_7FFF :
                ($signed(MAC_O) < -32'sd32768) ? 32'hFFFF_8000 : MAC_O;
`else
   assign res = MAC_O;
`endif
   always_ff @(posedge CLK or posedge RST)
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   always_comb
      state_d = (accept && cnt_q == CW'(TAPS - 1)) ? DRAIN :
                accept  ? ACCUM :
                capture ? OUT   :
                done    ? IDLE  : state_q;
   // The issue pipe mirrors the MAC product latency; "first" rides alongside so pair 0 loads.
   always_comb begin
      cnt_d    = done ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
      iss_d    = PIPE_LAT'({iss_q, accept});
      fst_d    = PIPE_LAT'({fst_q, accept && cnt_q == '0});
      a_d      = accept ? S_A : a_q;
      b_d      = accept ? S_B : b_q;
      last_d   = drained && !last_q;
      rdata_d  = capture ? res : rdata_q;
      rvalid_d = capture ? 1'b1 : done ? 1'b0 : rvalid_q;
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         cnt_q    <= '0;
         iss_q    <= '0;
         fst_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         last_q   <= 1'b0;
         alive_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         iss_q    <= iss_d;
         fst_q    <= fst_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         last_q   <= last_d;
         alive_q  <= 1'b1;
      end
   always_comb begin
      S_READY   = alive_q && (state_q == IDLE || state_q == ACCUM);
      MAC_A     = a_q;
      MAC_B     = b_q;
      MAC_OHHLD = !iss_q[PIPE_LAT-1];
      MAC_OLHLD = !iss_q[PIPE_LAT-1];
      MAC_OHLDA = iss_q[PIPE_LAT-1] && fst_q[PIPE_LAT-1];
      MAC_OLLDA = iss_q[PIPE_LAT-1] && fst_q[PIPE_LAT-1];
      MAC_OHADS = 1'b0;
      MAC_OLADS = 1'b0;
      R_VALID   = rvalid_q;
      R_DATA    = rdata_q;
   end
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: directed table plus random vectors for mac_dot_seq, with a behavioural MAC.
module tb_mac_dot_seq;
   logic        CLK = 1'b0, RST = 1'b1, S_VALID = 1'b0, R_READY = 1'b0;
   logic [15:0] S_A = '0, S_B = '0, MAC_A, MAC_B;
   logic        S_READY, MAC_OHHLD, MAC_OLHLD, MAC_OHLDA, MAC_OLLDA, MAC_OHADS, MAC_OLADS, R_VALID;
   logic [31:0] MAC_O, R_DATA;
   int tests = 0, fails = 0, ecnt = 0, ctl_bad = 0;
   bit lda_q[$];

   mac_dot_seq #(.TAPS(4), .PIPE_LAT(2)) dut (
      .CLK(CLK), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B),
      .MAC_A(MAC_A), .MAC_B(MAC_B), .MAC_OHHLD(MAC_OHHLD), .MAC_OLHLD(MAC_OLHLD),
      .MAC_OHLDA(MAC_OHLDA), .MAC_OLLDA(MAC_OLLDA), .MAC_OHADS(MAC_OHADS), .MAC_OLADS(MAC_OLADS),
      .MAC_O(MAC_O), .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA));

   always #5 CLK = ~CLK;
   always @(posedge CLK) ecnt++;

   // External MAC: one product register, then an accumulator that starts with garbage.
   logic signed [31:0] prod = 32'sd0, acc = 32'hDEAD_BEEF;
   assign MAC_O = acc;
   always @(posedge CLK) begin
      prod <= $signed(MAC_A) * $signed(MAC_B);
      if (!MAC_OHHLD) acc <= MAC_OHLDA ? prod : acc + prod;
   end

   always @(negedge CLK) begin
      if (!MAC_OHHLD) lda_q.push_back(MAC_OHLDA);
      if (MAC_OHHLD !== MAC_OLHLD || MAC_OHLDA !== MAC_OLLDA || MAC_OHADS !== 1'b0 || MAC_OLADS !== 1'b0)
         ctl_bad++;
   end

   typedef struct {
      logic [3:0][15:0] a, b;
      logic [31:0]      exp;
      bit               gaps;
      int               hold;
   } vec_t;

`ifdef MAC_DOT_SEQ_SAT_EN
   localparam logic [31:0] E_POS = 32'h0000_7FFF, E_NEG = 32'hFFFF_8000;
`else
   localparam logic [31:0] E_POS = 32'h0002_7100, E_NEG = 32'hFFFD_8F00;
`endif

   function automatic logic [31:0] ref_model(input logic [3:0][15:0] a, input logic [3:0][15:0] b);
      longint s = 0;
      logic [31:0] w;
      for (int i = 0; i < 4; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
      w = s[31:0];
`ifdef MAC_DOT_SEQ_SAT_EN
      if ($signed(w) > 32767) return 32'h0000_7FFF;
      if ($signed(w) < -32768) return 32'hFFFF_8000;
`endif
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_pair(input logic [15:0] a, input logic [15:0] b, output int last);
      int n = 0;
      S_VALID = 1'b1;
      S_A = a;
      S_B = b;
      while (!S_READY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      @(negedge CLK);
      last = ecnt;
   endtask

   task automatic run_vec(input vec_t v);
      int last = 0, n = 0, ones = 0;
      lda_q.delete();
      for (int i = 0; i < 4; i++) begin
         if (v.gaps) begin
            S_VALID = 1'b0;
            @(negedge CLK);
         end
         send_pair(v.a[i], v.b[i], last);
      end
      S_VALID = 1'b0;
      while (!R_VALID && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("latency", 32'(ecnt - last), 32'd4);
      check("r_data", R_DATA, v.exp);
      check("s_ready_in_out", {31'd0, S_READY}, 32'd0);
      for (int k = 0; k < v.hold; k++) begin
         S_VALID = 1'b1;
         S_A = 16'h5A5A;
         S_B = 16'hA5A5;
         @(negedge CLK);
         check("hold_r_data", R_DATA, v.exp);
         check("hold_r_valid", {31'd0, R_VALID}, 32'd1);
         check("hold_s_ready", {31'd0, S_READY}, 32'd0);
         check("hold_mac_a", {16'd0, MAC_A}, {16'd0, v.a[3]});
      end
      S_VALID = 1'b0;
      R_READY = 1'b1;
      @(negedge CLK);
      R_READY = 1'b0;
      check("r_valid_drop", {31'd0, R_VALID}, 32'd0);
      foreach (lda_q[i]) ones += int'(lda_q[i]);
      check("enables", 32'(lda_q.size()), 32'd4);
      check("first_lda", {31'd0, lda_q.size() > 0 ? lda_q[0] : 1'b0}, 32'd1);
      check("lda_count", 32'(ones), 32'd1);
   endtask

   initial begin
      vec_t tbl[7];
      vec_t r;
      int last;
      tbl[0] = '{{16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 32'h0000_0014, 1'b0, 0};
      tbl[1] = '{{4{16'hFFFD}}, {4{16'd1000}}, 32'hFFFF_D120, 1'b0, 0};
      tbl[2] = '{{4{16'd200}}, {4{16'd200}}, E_POS, 1'b0, 0};
      tbl[3] = '{{4{16'hFF38}}, {4{16'd200}}, E_NEG, 1'b0, 1};
      tbl[4] = '{{4{16'h8000}}, {4{16'h8000}}, 32'h0000_0000, 1'b0, 0};
      tbl[5] = '{{16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 32'h0000_0014, 1'b1, 0};
      tbl[6] = '{{16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 32'h0000_0014, 1'b0, 5};
      #1;
      check("rst_s_ready", {31'd0, S_READY}, 32'd0);
      check("rst_r_valid", {31'd0, R_VALID}, 32'd0);
      check("rst_hld", {31'd0, MAC_OHHLD}, 32'd1);
      check("rst_lda", {31'd0, MAC_OHLDA}, 32'd0);
      check("rst_mac_a", {16'd0, MAC_A}, 32'd0);
      check("rst_r_data", R_DATA, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("s_ready_pre_edge", {31'd0, S_READY}, 32'd0);
      @(negedge CLK);
      check("s_ready_post_edge", {31'd0, S_READY}, 32'd1);
      for (int i = 0; i < 7; i++) run_vec(tbl[i]);
      // Abort a vector after two pairs; the following vector must carry no residue.
      send_pair(16'd7, 16'd9, last);
      send_pair(16'd11, 16'd13, last);
      S_VALID = 1'b0;
      RST = 1'b1;
      #1;
      check("midrst_s_ready", {31'd0, S_READY}, 32'd0);
      check("midrst_hld", {31'd0, MAC_OHHLD}, 32'd1);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      run_vec(tbl[0]);
      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 4; i++) begin
            r.a[i] = (j % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 400) - 200);
            r.b[i] = (j % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 400) - 200);
         end
         r.gaps = 1'($urandom_range(0, 1));
         r.hold = $urandom_range(0, 2);
         r.exp  = ref_model(r.a, r.b);
         run_vec(r);
      end
      check("ctl_pairs", 32'(ctl_bad), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
